// File: rtl/seg7_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// seg7_pkg : shared constants for the 7-segment result display
// Rev 1.0
// ------------------------------------------------------------------
package seg7_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Active-low cathodes {g,f,e,d,c,b,a}, indexed by nibble value
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage
`default_nettype wire

// File: rtl/seg7_result_display_hex_to_seg7.sv
`default_nettype none
// ------------------------------------------------------------------
// hex_to_seg7 : combinational nibble to active-low segment lookup
// Rev 1.0
// ------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_nib];

endmodule
`default_nettype wire

// File: rtl/seg7_result_display.sv
`default_nettype none
// ------------------------------------------------------------------
// seg7_result_display : 8-digit multiplexed hex display of a result bus
// Rev 1.0
// ------------------------------------------------------------------
module seg7_result_display
  import seg7_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Result,
  input  logic [31:0] Result2,
  input  logic        sel,
  output logic [6:0]  LED,
  output logic [7:0]  Anode,
  output logic        frame_done
);

  logic [15:0] r_pcnt;
  logic [2:0]  r_idx;
  logic [31:0] r_snap;
  logic        w_tick;
  logic        w_last;
  logic [31:0] w_shift;
  logic        w_blank;
  logic [6:0]  w_seg;

  assign w_tick  = (r_pcnt == PRESCALE - 16'd1);
  assign w_last  = (r_idx == 3'(NUM_DIGITS - 1));
  // Upper part of the snapshot from the current digit upwards
  assign w_shift = r_snap >> {r_idx, 2'b00};
  assign w_blank = BLANK_LZ && (r_idx != 3'd0) && (w_shift == 32'd0);

  hex_to_seg7 u_hex_to_seg7 (
    .i_nib (w_shift[3:0]),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pcnt     <= 16'd0;
      r_idx      <= 3'd0;
      r_snap     <= 32'd0;
      frame_done <= 1'b0;
      Anode      <= AN_OFF;
      LED        <= SEG_OFF;
    end else begin
      r_pcnt     <= w_tick ? 16'd0 : r_pcnt + 16'd1;
      frame_done <= w_tick && w_last;
      if (w_tick) begin
        r_idx <= r_idx + 3'd1;
      end
      // Snapshot only at the frame wrap so a frame never mixes two values
      if (w_tick && w_last) begin
        r_snap <= sel ? Result2 : Result;
      end
      if (w_blank) begin
        Anode <= AN_OFF;
        LED   <= SEG_OFF;
      end else begin
        Anode <= ~(8'b1 << r_idx);
        LED   <= w_seg;
      end
    end
  end

endmodule
`default_nettype wire
